// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
//   INSTR_W      : instruction word width
//   DEF_ADDR_W   : default PC / memory word-address width
//   DEF_DEPTH    : default prefetch queue depth
//   fetch_state_e: RUN (responses enqueued) / DRAIN (stale responses discarded)
package instruction_fetch_unit_pkg;

  localparam int INSTR_W    = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instr} pairs.
//   clock, reset          : clock, asynchronous active-high reset
//   push, push_pc/instr   : enqueue request and payload
//   pop                   : dequeue head (ignored when empty)
//   flush                 : discard all entries (wins over push/pop)
//   head_valid/pc/instr   : head entry; pc/instr read as zero when empty
//   count                 : current occupancy 0..DEPTH
module instruction_fetch_unit_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_pc,
  input  logic [INSTR_W-1:0]      push_instr,
  input  logic                    pop,
  input  logic                    flush,
  output logic                    head_valid,
  output logic [ADDR_W-1:0]       head_pc,
  output logic [INSTR_W-1:0]      head_instr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign do_pop     = pop && head_valid;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; the head is masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
  assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word reads
// to instruction memory, buffers returned words and hands {pc, instr} to the
// core. A redirect flushes queued words and discards in-flight responses.
//   clock, reset                     : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc      : core-resolved control transfer
//   imem_req_valid/ready/addr        : request channel to instruction memory
//   imem_rsp_valid/data              : in-order response channel, no backpressure
//   fetch_valid/ready/instr/pc       : head of prefetch queue to the core
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0]  fetch_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  drop_cnt_next;
  logic [CNT_W:0]    occupancy;
  logic              accept;
  logic              enq;
  logic              flush;

  // Credit: queued plus in-flight words never exceed the queue depth, so a
  // response always finds room and never needs to be refused.
  assign occupancy        = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid   = !reset && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_req_addr    = req_pc;
  assign accept           = imem_req_valid && imem_req_ready;
  assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

  // In RUN every in-flight request belongs to the current stream, so the
  // oldest one (the one answering now) sits 'outstanding' words behind req_pc.
  assign rsp_pc = req_pc - ADDR_W'(outstanding);

  always_comb begin
    state_next    = state;
    drop_cnt_next = drop_cnt;
    enq           = 1'b0;
    flush         = 1'b0;
    if (redirect_valid) begin
      flush         = 1'b1;
      drop_cnt_next = outstanding_next;
      state_next    = (outstanding_next != '0) ? DRAIN : RUN;
    end else begin
      case (state)
        RUN: begin
          enq = imem_rsp_valid;
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            drop_cnt_next = drop_cnt - 1'b1;
            if (drop_cnt == CNT_W'(1)) state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      req_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (redirect_valid) req_pc <= redirect_pc;
      else if (accept)    req_pc <= req_pc + 1'b1;
    end
  end

  instruction_fetch_unit_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (enq),
    .push_pc    (rsp_pc),
    .push_instr (imem_rsp_data),
    .pop        (fetch_ready),
    .flush      (flush),
    .head_valid (fetch_valid),
    .head_pc    (fetch_pc),
    .head_instr (fetch_instr),
    .count      (count)
  );

endmodule
